// File: rtl/vit_pkg.sv
// Shared Viterbi decoder types: received pair, BMC FSM state,
// and the default trellis frame length.
package vit_pkg;

    localparam int FRAME_LEN_DEF = 16;

    typedef logic [1:0] rx_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TB   = 2'd2
    } bmc_state_t;

endpackage

// File: rtl/bmc_fifo.sv
// Small input FIFO of received pairs for bmc_ctrl.
// Ports: clk, rst_n, clear, push/push_data, pop/pop_data, full, empty.
module bmc_fifo
    import vit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear,
    input  logic     push,
    input  rx_pair_t push_data,
    input  logic     pop,
    output rx_pair_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    rx_pair_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmc_ctrl.sv
// Branch-metric front end: buffers rx pairs and issues one frame of
// trellis steps to ACS, then requests traceback before the next frame.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_pair;
// bmc_valid/acs_ready/bmc_pair; step_cnt; frame_start/frame_end;
// tb_req/tb_busy.
module bmc_ctrl
    import vit_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int CW        = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  rx_pair_t      in_pair,
    output logic          bmc_valid,
    input  logic          acs_ready,
    output rx_pair_t      bmc_pair,
    output logic [CW-1:0] step_cnt,
    output logic          frame_start,
    output logic          frame_end,
    output logic          tb_req,
    input  logic          tb_busy
);

    bmc_state_t state;
    bmc_state_t state_d;
    rx_pair_t   head;
    logic       full;
    logic       empty;
    logic       rdy_q;
    logic       push;
    logic       load;
    logic       acc;
    logic       last;
    logic       end_acc;

    // rdy_q keeps in_ready low until the first edge out of reset.
    assign in_ready = rdy_q && !full && !flush;
    assign push     = in_valid && in_ready;
    assign last     = (step_cnt == CW'(FRAME_LEN - 1));
    assign acc      = bmc_valid && acs_ready;
    assign end_acc  = acc && last;

    // The frame_end beat never refills the register: traceback first.
    assign load = (state == ST_RUN) && !flush && !end_acc
                && (!bmc_valid || acs_ready) && !empty;

    assign frame_start = bmc_valid && (step_cnt == '0);
    assign frame_end   = bmc_valid && last;

    bmc_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .push     (push),
        .push_data(in_pair),
        .pop      (load),
        .pop_data (head),
        .full     (full),
        .empty    (empty)
    );

    // tb_req is high only on the first TB cycle, so it also blocks exit.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (!empty && !tb_busy) state_d = ST_RUN;
            ST_RUN:  if (end_acc) state_d = ST_TB;
            ST_TB:   if (!tb_req && !tb_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rdy_q     <= 1'b0;
            bmc_valid <= 1'b0;
            bmc_pair  <= '0;
            step_cnt  <= '0;
            tb_req    <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            rdy_q     <= 1'b1;
            bmc_valid <= 1'b0;
            bmc_pair  <= '0;
            step_cnt  <= '0;
            tb_req    <= 1'b0;
        end else begin
            state  <= state_d;
            rdy_q  <= 1'b1;
            tb_req <= (state == ST_RUN) && end_acc;
            if (acc) begin
                step_cnt <= last ? '0 : step_cnt + 1'b1;
            end
            if (load) begin
                bmc_valid <= 1'b1;
                bmc_pair  <= head;
            end else if (acc) begin
                bmc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bmc_ctrl.md
BMC_CTRL -- requirements
Module: bmc_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: input FIFO entries, power of two, >=2.
REQ-002 SHALL have parameter FRAME_LEN, default 16: trellis steps per frame, >=2; CW = $clog2(FRAME_LEN).
REQ-003 SHALL have clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have flush  in  1: synchronous abort of the current frame.
REQ-006 SHALL have in_valid  in  1 / in_ready  out  1 / in_pair  in  2: received symbol-pair input handshake.
REQ-007 SHALL have bmc_valid  out  1 / acs_ready  in  1 / bmc_pair  out  2: pair presented to the branch-metric bank, accepted by ACS.
REQ-008 SHALL have step_cnt  out  CW: trellis index of the pair on bmc_pair.
REQ-009 SHALL have frame_start  out  1 / frame_end  out  1: qualify the first / last step of a frame.
REQ-010 SHALL have tb_req  out  1 / tb_busy  in  1: traceback start pulse / traceback unit busy.

Function
REQ-011 SHALL accept an input beat when in_valid && in_ready; in_ready = !fifo_full && !flush (no write-through when full).
REQ-012 SHALL implement FSM states IDLE, RUN, TB.
REQ-013 SHALL move IDLE->RUN when the FIFO is non-empty and tb_busy==0.
REQ-014 SHALL, in RUN, load the output register from the FIFO head when the register is empty or being accepted (bmc_valid && acs_ready) and the FIFO is non-empty.
REQ-015 SHALL give latency: a pair written at edge t into an empty FIFO in RUN appears on bmc_pair with bmc_valid=1 after edge t+1.
REQ-016 SHALL hold bmc_pair, step_cnt, frame_start and frame_end stable while bmc_valid && !acs_ready.
REQ-017 SHALL increment step_cnt on each accepted output; step_cnt wraps FRAME_LEN-1 -> 0.
REQ-018 SHALL drive frame_start = bmc_valid && step_cnt==0 and frame_end = bmc_valid && step_cnt==FRAME_LEN-1.
REQ-019 SHALL move RUN->TB on acceptance of the frame_end beat; no further pair is loaded in that edge.
REQ-020 SHALL assert tb_req for exactly the first cycle in TB.
REQ-021 SHALL leave TB for IDLE on the first cycle after the tb_req cycle in which tb_busy==0.
REQ-022 SHALL keep accepting input into the FIFO while in IDLE and TB; only output loading stalls.
REQ-023 SHALL, on flush=1, at the next edge: empty the FIFO, clear bmc_valid, set step_cnt=0, enter IDLE; no tb_req is issued; an in_valid beat in that cycle is dropped.
REQ-024 SHALL give flush priority over every simultaneous event (push, pop, acceptance, FSM transition).
REQ-025 SHALL make a simultaneous push and pop on a non-full FIFO leave the occupancy unchanged.

Reset
REQ-026 SHALL, while rst_n==0, force: FSM=IDLE, FIFO empty, bmc_valid=0, bmc_pair=2'b00, step_cnt=0, tb_req=0, frame_start=0, frame_end=0, in_ready=0.
REQ-027 SHALL drive in_ready=1 from the first edge after rst_n deasserts.
REQ-028 SHALL discard a frame in progress when reset is asserted mid-frame; no tb_req is issued for it.

Structure
REQ-029 SHALL take the pair type (2-bit rx pair), the FSM state enum and the default FRAME_LEN from shared package vit_pkg.
REQ-030 SHALL contain one sub-module bmc_fifo (parameter DEPTH; push/pop/full/empty; asynchronous active-low reset; synchronous clear used by flush).
REQ-031 SHALL keep bmc_pair registered so the downstream bmc units see a glitch-free input.

Verification
REQ-032 SHALL cover streaming: FRAME_LEN=4, acs_ready=1, tb_busy=0, pairs 00,01,10,11 on consecutive cycles -> bmc_pair 00,01,10,11 with step_cnt 0..3, frame_start on 00, frame_end on 11, one tb_req pulse the following cycle.
REQ-033 SHALL cover backpressure: acs_ready=0 for 3 cycles while bmc_pair=10 -> bmc_pair and step_cnt held, FIFO fills to DEPTH=4, in_ready=0, no beat lost after release.
REQ-034 SHALL cover traceback stall: tb_busy=1 for 5 cycles after tb_req, with 2 pairs queued -> bmc_valid stays 0 until tb_busy=0, then the next frame starts with step_cnt=0 and frame_start=1.
REQ-035 SHALL cover flush: flush at step_cnt=2 with 3 pairs queued -> next cycle FIFO empty, bmc_valid=0, step_cnt=0, no tb_req, concurrent input dropped.
REQ-036 SHALL cover reset: rst_n pulsed low asynchronously mid-frame -> all outputs at reset values immediately; the first post-reset pair is issued with step_cnt=0.
REQ-037 SHALL cover simultaneous push/pop: with the FIFO at 2 entries, push and pop in the same cycle -> occupancy stays 2 and order is preserved.
